// File: rtl/fetch_sequencer.sv
`default_nettype none
// ==========================================================================
// fetch_sequencer : PC / instruction-register controller for program memory
// Optional feature macro: FETCH_SELFLOOP_HALT_EN (jump-to-self enters HALT)
// Revision: 1.0
// ==========================================================================
module fetch_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 17,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  pc_addr,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               halt_req,
  output logic [INSTR_W-1:0] ir_out,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               pc_wrap,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic [INSTR_W-1:0] ir_n;
  logic               ir_valid_n;
  logic [ADDR_W-1:0]  ir_pc_n;
  logic               pc_wrap_n;
  logic               halted_n;
  logic [CNT_W-1:0]   fetch_count_n;
  logic               do_fetch;
  logic               selfloop_hit;

  assign pc_addr = pc;

`ifdef FETCH_SELFLOOP_HALT_EN
  // Only a valid IR identifies "the current instruction"; a bubble has no owner.
  assign selfloop_hit = ir_valid && (redirect_target == ir_pc);
`else
  assign selfloop_hit = 1'b0;
`endif

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    ir_n          = ir_out;
    ir_valid_n    = ir_valid;
    ir_pc_n       = ir_pc;
    pc_wrap_n     = 1'b0;
    halted_n      = halted;
    fetch_count_n = fetch_count;
    do_fetch      = 1'b0;

    case (state)
      BOOT: begin
        state_n = RUN;
      end
      RUN: begin
        if (halt_req || (redirect_valid && selfloop_hit)) begin
          state_n    = HALT;
          ir_valid_n = 1'b0;
          halted_n   = 1'b1;
        end else if (redirect_valid) begin
          state_n    = FLUSH;
          pc_n       = redirect_target;
          ir_valid_n = 1'b0;
        end else if (!stall) begin
          do_fetch = 1'b1;
        end
      end
      FLUSH: begin
        // The bubble cycle fetches the target, so exactly one invalid cycle is seen.
        if (halt_req || (redirect_valid && selfloop_hit)) begin
          state_n    = HALT;
          ir_valid_n = 1'b0;
          halted_n   = 1'b1;
        end else if (redirect_valid) begin
          pc_n = redirect_target;
        end else begin
          state_n  = RUN;
          do_fetch = 1'b1;
        end
      end
      HALT: begin
        ir_valid_n = 1'b0;
      end
      default: begin
        state_n = BOOT;
      end
    endcase

    if (do_fetch) begin
      ir_n       = instr_in;
      ir_pc_n    = pc;
      ir_valid_n = 1'b1;
      pc_n       = pc + PC_ONE;
      pc_wrap_n  = (pc == {ADDR_W{1'b1}});
      if (fetch_count != {CNT_W{1'b1}}) begin
        fetch_count_n = fetch_count + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      ir_out      <= '0;
      ir_valid    <= 1'b0;
      ir_pc       <= '0;
      pc_wrap     <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      ir_out      <= ir_n;
      ir_valid    <= ir_valid_n;
      ir_pc       <= ir_pc_n;
      pc_wrap     <= pc_wrap_n;
      halted      <= halted_n;
      fetch_count <= fetch_count_n;
    end
  end

endmodule
`default_nettype wire
